// File: rtl/mem_pkg.sv
// mem_pkg: decoder load/store codes, access sizes and FSM state shared by the memory access unit.
package mem_pkg;
  localparam logic [2:0] RC_LB  = 3'b000;
  localparam logic [2:0] RC_LBU = 3'b001;
  localparam logic [2:0] RC_LH  = 3'b010;
  localparam logic [2:0] RC_LHU = 3'b011;
  localparam logic [2:0] RC_LW  = 3'b100;
  localparam logic [1:0] WC_SW  = 2'b00;
  localparam logic [1:0] WC_SH  = 2'b01;
  localparam logic [1:0] WC_SB  = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication, load extract/extension and misalign flag.
// The misalign flag is only produced when MEM_ALIGN_CHECK_EN is defined.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        i_we,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_rc,
  input  logic [1:0]  i_wc,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  size_t       w_sz;
  logic        w_sgn;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // Undefined codes fall through to full-word size.
  assign w_sz = i_we ? (i_wc == WC_SB ? SZ_B : i_wc == WC_SH ? SZ_H : SZ_W)
                     : ((i_rc == RC_LB || i_rc == RC_LBU) ? SZ_B
                     : (i_rc == RC_LH || i_rc == RC_LHU) ? SZ_H : SZ_W);
  assign w_sgn  = i_rc == RC_LB || i_rc == RC_LH;
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign o_be = w_sz == SZ_B ? 4'b0001 << i_addr_lo
              : w_sz == SZ_H ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign o_wdata = w_sz == SZ_B ? {4{i_wdata[7:0]}}
                 : w_sz == SZ_H ? {2{i_wdata[15:0]}} : i_wdata;
  assign o_rdata = w_sz == SZ_B ? {{24{w_sgn & w_byte[7]}}, w_byte}
                 : w_sz == SZ_H ? {{16{w_sgn & w_half[15]}}, w_half} : i_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  assign o_misalign = (w_sz == SZ_H && i_addr_lo[0]) || (w_sz == SZ_W && i_addr_lo != 2'b00);
`else
  assign o_misalign = 1'b0;
`endif
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer over a single-outstanding valid/ack bus.
// Define MEM_ALIGN_CHECK_EN to fail misaligned half/word accesses without touching the bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  readcontrol,
  input  logic [1:0]  writecontrol,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  state_t      r_state, w_next;
  logic        r_we, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_rc;
  logic [1:0]  r_wc;
  logic [7:0]  r_cnt;
  logic        w_idle, w_issue, w_resp, w_accept, w_tmo, w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  assign w_idle   = r_state == S_IDLE;
  assign w_issue  = r_state == S_ISSUE;
  assign w_resp   = r_state == S_RESP;
  assign w_accept = w_idle && req_valid;
  assign w_tmo    = r_cnt == 8'(TIMEOUT_CYCLES - 1);
  // In IDLE the aligner looks at the incoming request so misalignment is known at the accept edge.
  mem_lane_align u_align (
    .i_we       (w_idle ? req_we : r_we),
    .i_addr_lo  (w_idle ? req_addr[1:0] : r_addr[1:0]),
    .i_rc       (w_idle ? readcontrol : r_rc),
    .i_wc       (w_idle ? writecontrol : r_wc),
    .i_wdata    (r_wdata),
    .i_rdata    (bus_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ext),
    .o_misalign (w_misalign)
  );
  always_comb begin
    w_next = w_idle ? (w_accept ? (w_misalign ? S_RESP : S_ISSUE) : S_IDLE)
           : w_issue ? ((bus_ack || w_tmo) ? S_RESP : S_ISSUE) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rc    <= '0;
      r_wc    <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_rc    <= readcontrol;
      r_wc    <= writecontrol;
      r_err   <= w_misalign;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else if (w_issue) begin
      if (bus_ack) begin
        r_rdata <= r_we ? 32'd0 : w_ext;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
  assign req_ready  = w_idle;
  assign stall      = !w_idle;
  assign bus_req    = w_issue;
  assign bus_we     = w_issue && r_we;
  assign bus_addr   = w_issue ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus_be     = w_issue ? w_be : 4'd0;
  assign bus_wdata  = (w_issue && r_we) ? w_wdata : 32'd0;
  assign resp_valid = w_resp;
  assign resp_rdata = w_resp ? r_rdata : 32'd0;
  assign resp_err   = w_resp && r_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory access unit with a 4-cycle bus timeout.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  readcontrol = '0;
  logic [1:0]  writecontrol = '0;
  logic        resp_valid, resp_err, stall, bus_req, bus_we;
  logic [31:0] resp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .readcontrol(readcontrol), .writecontrol(writecontrol),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic accept(input logic we, input logic [31:0] addr, wd, input logic [2:0] rc, input logic [1:0] wc);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b expected 1", req_ready); end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; readcontrol = rc; writecontrol = wc;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    readcontrol = 3'($urandom); writecontrol = 2'($urandom);
  endtask

  task automatic xact(input string nm, input logic we, input logic [31:0] addr, wd, input logic [2:0] rc,
                      input logic [1:0] wc, input int wt, input logic [31:0] rd, input logic [3:0] ebe,
                      input logic [31:0] ewd, erd);
    accept(we, addr, wd, rc, wc);
    for (int i = 0; i <= wt; i++) begin
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, we, addr & ~32'd3, ebe}) begin
        errors++;
        $display("FAIL %s_bus c%0d: got req=%b we=%b addr=%h be=%b expected req=1 we=%b addr=%h be=%b",
                 nm, i, bus_req, bus_we, bus_addr, bus_be, we, addr & ~32'd3, ebe);
      end
      if (we) begin
        checks++;
        if (bus_wdata !== ewd) begin errors++; $display("FAIL %s_wdata: got %h expected %h", nm, bus_wdata, ewd); end
      end
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s_early_resp: got %b expected 0", nm, resp_valid); end
      if (i == wt) begin bus_ack = 1'b1; bus_rdata = rd; end
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
    end
    checks++;
    if ({resp_valid, resp_err, resp_rdata, bus_req} !== {1'b1, 1'b0, erd, 1'b0}) begin
      errors++;
      $display("FAIL %s_resp: got v=%b err=%b rdata=%h req=%b expected v=1 err=0 rdata=%h req=0",
               nm, resp_valid, resp_err, resp_rdata, bus_req, erd);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready, stall} !== 3'b010) begin
      errors++;
      $display("FAIL %s_after: got v=%b ready=%b stall=%b expected v=0 ready=1 stall=0", nm, resp_valid, req_ready, stall);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({req_ready, stall, bus_req, bus_we, resp_valid, resp_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b stall=%b req=%b we=%b v=%b err=%b expected 100000",
               req_ready, stall, bus_req, bus_we, resp_valid, resp_err);
    end
    checks++;
    if ({bus_addr, bus_be, bus_wdata, resp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h be=%b wdata=%h rdata=%h expected all 0", bus_addr, bus_be, bus_wdata, resp_rdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stores;
    xact("sb", 1'b1, 32'h1003, 32'h000000A5, 3'd0, 2'b10, 2, 32'h11223344, 4'b1000, 32'hA5A5A5A5, 32'h0);
    xact("sb0", 1'b1, 32'h1000, 32'h123456C3, 3'd0, 2'b10, 0, 32'h0, 4'b0001, 32'hC3C3C3C3, 32'h0);
    xact("sh", 1'b1, 32'h1002, 32'h1234BEEF, 3'd0, 2'b01, 1, 32'hFFFFFFFF, 4'b1100, 32'hBEEFBEEF, 32'h0);
    xact("sw", 1'b1, 32'h1004, 32'hDEADBEEF, 3'd0, 2'b00, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0);
    xact("sw11", 1'b1, 32'h1008, 32'hCAFEF00D, 3'd0, 2'b11, 0, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0);
  endtask

  task automatic test_loads;
    xact("lb", 1'b0, 32'h2002, 32'h0, 3'b000, 2'd0, 0, 32'h12F03456, 4'b0100, 32'h0, 32'hFFFFFFF0);
    xact("lbu", 1'b0, 32'h2002, 32'h0, 3'b001, 2'd0, 1, 32'h12F03456, 4'b0100, 32'h0, 32'h000000F0);
    xact("lb1", 1'b0, 32'h2001, 32'h0, 3'b000, 2'd0, 0, 32'h12F03456, 4'b0010, 32'h0, 32'h00000034);
    xact("lh", 1'b0, 32'h2002, 32'h0, 3'b010, 2'd0, 0, 32'h8001FFFF, 4'b1100, 32'h0, 32'hFFFF8001);
    xact("lhu", 1'b0, 32'h2002, 32'h0, 3'b011, 2'd0, 0, 32'h8001FFFF, 4'b1100, 32'h0, 32'h00008001);
    xact("lh0", 1'b0, 32'h2000, 32'h0, 3'b010, 2'd0, 0, 32'h8001FFFF, 4'b0011, 32'h0, 32'hFFFFFFFF);
    xact("lw", 1'b0, 32'h2000, 32'h0, 3'b100, 2'd0, 0, 32'h8001FFFF, 4'b1111, 32'h0, 32'h8001FFFF);
    xact("lw111", 1'b0, 32'h2004, 32'h0, 3'b111, 2'd0, 0, 32'h80000001, 4'b1111, 32'h0, 32'h80000001);
  endtask

  task automatic test_timeout;
    accept(1'b0, 32'h2008, 32'h0, 3'b100, 2'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus_req, resp_valid} !== 2'b10) begin
        errors++;
        $display("FAIL tmo_req c%0d: got req=%b v=%b expected req=1 v=0", i, bus_req, resp_valid);
      end
      @(negedge clk);
    end
    checks++;
    if ({bus_req, resp_valid, resp_err, resp_rdata} !== {3'b011, 32'h0}) begin
      errors++;
      $display("FAIL tmo_resp: got req=%b v=%b err=%b rdata=%h expected req=0 v=1 err=1 rdata=0",
               bus_req, resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL tmo_after: got v=%b ready=%b expected v=0 ready=1", resp_valid, req_ready); end
    xact("ack_at_tmo", 1'b0, 32'h200C, 32'h0, 3'b100, 2'd0, 3, 32'h5A5A0001, 4'b1111, 32'h0, 32'h5A5A0001);
  endtask

  task automatic test_stray_ack;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({resp_valid, bus_req, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL stray_ack: got v=%b req=%b ready=%b expected v=0 req=0 ready=1", resp_valid, bus_req, req_ready);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_misalign;
`ifdef MEM_ALIGN_CHECK_EN
    accept(1'b0, 32'h3002, 32'h0, 3'b100, 2'd0);
    checks++;
    if ({bus_req, resp_valid, resp_err, resp_rdata} !== {3'b011, 32'h0}) begin
      errors++;
      $display("FAIL misalign_resp: got req=%b v=%b err=%b rdata=%h expected req=0 v=1 err=1 rdata=0",
               bus_req, resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({bus_req, resp_valid, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL misalign_after: got req=%b v=%b ready=%b expected 001", bus_req, resp_valid, req_ready);
    end
`else
    xact("lw_unal", 1'b0, 32'h3002, 32'h0, 3'b100, 2'd0, 0, 32'h76543210, 4'b1111, 32'h0, 32'h76543210);
    xact("sh_odd", 1'b1, 32'h3001, 32'h0000ABCD, 3'd0, 2'b01, 0, 32'h0, 4'b0011, 32'hABCDABCD, 32'h0);
`endif
  endtask

  task automatic test_reset_mid;
    accept(1'b0, 32'h4000, 32'h0, 3'b000, 2'd0);
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b expected 1", bus_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, req_ready, stall} !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_async: got req=%b ready=%b stall=%b expected 010", bus_req, req_ready, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rstmid_idle c%0d: got v=%b ready=%b expected v=0 ready=1", i, resp_valid, req_ready);
      end
    end
    xact("post_rst", 1'b0, 32'h4004, 32'h0, 3'b011, 2'd0, 0, 32'hABCD1234, 4'b0011, 32'h0, 32'h00001234);
  endtask

  task automatic test_back_to_back;
    xact("b2b_a", 1'b1, 32'h5000, 32'h01020304, 3'd0, 2'b00, 0, 32'h0, 4'b1111, 32'h01020304, 32'h0);
    xact("b2b_b", 1'b0, 32'h5003, 32'h0, 3'b001, 2'd0, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'h00000080);
  endtask

  initial begin
    test_reset;
    test_stores;
    test_loads;
    test_timeout;
    test_stray_ack;
    test_misalign;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access sequencer for the MEM stage of the pipelined MIPS core. It accepts one load/store per transaction, using the 3-bit `readcontrol` and 2-bit `writecontrol` codes produced by the main decoder. It drives a single-outstanding valid/ack data bus with byte enables and lane-replicated write data. Load data is returned sign- or zero-extended, with a bus-timeout error.

## Interface
- `TIMEOUT_CYCLES`, default 16: ISSUE cycles without `bus_ack` before abort. Legal range is 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: the pipeline presents an access.
- `req_ready` out 1: the unit can accept an access. High only in IDLE.
- `req_we` in 1: 1 = store (decoder `memwrite`), 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits for sb/sh.
- `readcontrol` in 3: load code. 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw.
- `writecontrol` in 2: store code. 00 sw, 01 sh, 10 sb.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. It is 0 for stores and on error.
- `resp_err` out 1: error flag, valid with `resp_valid`.
- `stall` out 1: high in every state except IDLE.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: write data.
- `bus_ack` in 1: bus completion.
- `bus_rdata` in 32: read data, valid with `bus_ack`.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- Reset puts the FSM in IDLE. All outputs are 0 except `req_ready`, which is 1.
- IDLE:
  - When `req_valid` and `req_ready` are both high, the unit latches we, addr, wdata and the codes, then goes to ISSUE.
  - Inputs are ignored after the accept edge.
- ISSUE:
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are held stable until ack.
  - On `bus_ack`, the unit captures `bus_rdata` and goes to RESP with err=0.
  - The timeout counter clears on entry and increments each ISSUE cycle without ack. When it reaches `TIMEOUT_CYCLES`, the unit drops `bus_req` and goes to RESP with err=1.
  - An ack arriving in the same cycle as the timeout wins: err=0.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then IDLE.
- Byte lanes are little-endian; lane k is bits 8k+7:8k.
  - sb: `bus_be` = 1<<addr[1:0]; wdata is byte[7:0] replicated ×4.
  - sh: `bus_be` = addr[1] ? 1100 : 0011; wdata is half[15:0] replicated ×2.
  - sw: `bus_be` = 1111.
  - Loads drive `bus_be` with the same masks for lb/lbu, lh/lhu and lw.
- Load extract:
  - Byte selected by addr[1:0].
  - Half selected by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Undefined codes: readcontrol 101–111 behaves as lw; writecontrol 11 behaves as sw.
- `bus_ack` outside ISSUE is ignored. `bus_ack` is never treated as a new response.

## Timing
- Accept edge at the end of cycle N. `bus_req` is high in N+1.
- The earliest ack is in N+1, giving `resp_valid` in N+2 and `req_ready` in N+3.
- Total latency is 2 + (ack wait) cycles. Timeout gives `resp_valid` in cycle N+1+`TIMEOUT_CYCLES`.
- Back-to-back accesses are possible every 3 cycles minimum.
- `rst_n` low mid-transaction immediately (asynchronously) drops `bus_req`, clears the counter and enters IDLE. There is no response for the aborted access.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misalignment is lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - A misaligned access skips the bus (`bus_req` never rises) and goes IDLE→ISSUE-bypass→RESP with err=1, `resp_valid` in N+1.
- `MEM_ALIGN_CHECK_EN` undefined:
  - No check; the irrelevant low address bits are ignored (half uses addr[1], word uses none).
  - All accesses go to the bus.

## Structure
- Shared package `mem_pkg` holds:
  - readcontrol code localparams `RC_LB`/`RC_LBU`/`RC_LH`/`RC_LHU`/`RC_LW`;
  - writecontrol code localparams `WC_SW`/`WC_SH`/`WC_SB`;
  - the FSM state typedef.
- One combinational sub-module, `mem_lane_align`, computes `bus_be`, replicated wdata, the load extract/extension and the misalign flag.
- The top level holds the FSM, latches and timeout counter.

## Test plan
- sb addr 0x1003, wdata 0x000000A5, ack after 2 cycles -> `bus_be`=1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x1000, `resp_valid` 1 cycle, err=0.
- lb addr 0x2002, `bus_rdata` 0x12F03456 -> `resp_rdata`=0xFFFFFFF0; lbu same -> 0x000000F0.
- lh addr 0x2002, rdata 0x8001FFFF -> 0xFFFF8001; lhu -> 0x00008001; lw -> 0x8001FFFF.
- No ack, `TIMEOUT_CYCLES`=4 -> `bus_req` high exactly 4 cycles, then `resp_valid` err=1 rdata=0; ack on the 4th cycle -> err=0.
- lw addr 0x3002 -> with `MEM_ALIGN_CHECK_EN`: no `bus_req`, err=1 at N+1; without: bus access to 0x3000, err=0.
- `rst_n` pulsed low during ISSUE -> `bus_req` drops asynchronously, no `resp_valid`, `req_ready`=1 after release; a new access completes normally.
